// File: rtl/pixel_readout.sv
// ---------------------------------------------------------------------------
// pixel_readout
//
// Purpose:
//   This is the stage after pixelTop. When frameValid strobes, it captures the
//   flattened pixel array into a shadow register. It then streams the pixels
//   out one byte per beat over a valid/ready handshake, in row-major order
//   (pixel 0 first). Any frameValid that arrives while a frame is still
//   draining is dropped, and the sticky overrun flag records the loss.
//
// Optional feature:
//   READOUT_CRC_EN - When this macro is defined, a running XOR of the N pixel
//                    bytes is appended as one extra beat. That beat is sent
//                    from the CHK state and carries lastOut. Without the
//                    macro, a frame is exactly N beats and lastOut is set on
//                    pixel N-1.
//
// Parameters:
//   W, H          pixel array width / height
//   N             total pixel count (H*W), must be >= 2
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   reset         asynchronous, active-high; clears all state
//   pixelDataIn   flattened frame, pixel k at [8k+7:8k]
//   frameValid    one-cycle strobe marking a complete frame on pixelDataIn
//   dataOut       current output byte
//   dataValid     dataOut is valid this cycle
//   dataReady     consumer accepts the beat when dataValid && dataReady
//   firstOut      current beat is pixel 0
//   lastOut       current beat is the final beat of the frame
//   busy          a captured frame has not fully drained yet
//   overrun       sticky: a frameValid was dropped (cleared only by reset)
//
// All outputs come straight from flops. There is no combinational path from
// dataReady or frameValid to any output.
// ---------------------------------------------------------------------------
module pixel_readout #(
    parameter int W = 3,
    parameter int H = 2,
    parameter int N = H * W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8*N-1:0] pixelDataIn,
    input  logic           frameValid,
    output logic [7:0]     dataOut,
    output logic           dataValid,
    input  logic           dataReady,
    output logic           firstOut,
    output logic           lastOut,
    output logic           busy,
    output logic           overrun
);

    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1
`ifdef READOUT_CRC_EN
        ,
        S_CHK    = 2'd2
`endif
    } state_e;

    state_e         state_q,   state_d;
    logic [IW-1:0]  idx_q,     idx_d;
    logic [8*N-1:0] shadow_q,  shadow_d;
    logic [7:0]     data_q,    data_d;
    logic           valid_q,   valid_d;
    logic           first_q,   first_d;
    logic           last_q,    last_d;
    logic           overrun_q, overrun_d;
`ifdef READOUT_CRC_EN
    logic [7:0]     crc_q,     crc_d;
`endif

    logic           beat;
    logic [IW-1:0]  idx_inc;
    logic [7:0]     next_byte;

    assign beat    = valid_q && dataReady;
    assign idx_inc = idx_q + 1'b1;

    // This selects the byte that is presented after the current beat. The
    // explicit mux keeps the select in range when idx_inc would step past N-1.
    // That value is never used, but the select is still evaluated.
    always_comb begin
        next_byte = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (idx_inc == IW'(k)) begin
                next_byte = shadow_q[8*k +: 8];
            end
        end
    end

    // The next output values are computed here so that every output can be
    // registered directly.
    always_comb begin
        // NOTE: every variable gets a hold-value default before the case.
        // Without the default, a path that skips an assignment would infer
        // a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        valid_d   = valid_q;
        first_d   = first_q;
        last_d    = last_q;
        overrun_d = overrun_q;
`ifdef READOUT_CRC_EN
        crc_d     = crc_q;
`endif

        // A frame that arrives while another is still draining is dropped.
        // This includes the cycle of the final handshake.
        if (frameValid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frameValid) begin
                    shadow_d = pixelDataIn;
                    idx_d    = '0;
                    state_d  = S_STREAM;
                    data_d   = pixelDataIn[7:0];
                    valid_d  = 1'b1;
                    first_d  = 1'b1;
                    last_d   = 1'b0;   // N >= 2, so pixel 0 is never last
`ifdef READOUT_CRC_EN
                    crc_d    = 8'h00;
`endif
                end
            end

            S_STREAM: begin
                if (beat) begin
                    first_d = 1'b0;
`ifdef READOUT_CRC_EN
                    crc_d   = crc_q ^ data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef READOUT_CRC_EN
                        // The check byte includes the pixel just accepted.
                        state_d = S_CHK;
                        data_d  = crc_q ^ data_q;
                        last_d  = 1'b1;
`else
                        state_d = S_IDLE;
                        data_d  = 8'h00;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
`endif
                    end else begin
                        idx_d  = idx_inc;
                        data_d = next_byte;
`ifdef READOUT_CRC_EN
                        last_d = 1'b0;
`else
                        last_d = (idx_inc == LAST_IDX);
`endif
                    end
                end
            end

`ifdef READOUT_CRC_EN
            S_CHK: begin
                if (beat) begin
                    state_d = S_IDLE;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                data_d  = 8'h00;
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shadow register is reset like any other register.
            // After reset, the outputs and a re-read shadow must read as zero,
            // not as whatever the flops powered up with.
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef READOUT_CRC_EN
            crc_q     <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments make all flops update together
            // from the values they held before the edge.
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
`ifdef READOUT_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

    assign dataOut   = data_q;
    assign dataValid = valid_q;
    assign firstOut  = first_q;
    assign lastOut   = last_q;
    assign busy      = valid_q;   // valid is high exactly in STREAM/CHK
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_readout.sv
// ---------------------------------------------------------------------------
// tb_pixel_readout
//
// Directed testbench for pixel_readout with W=3, H=2 (N=6). Expected streams
// are built from the bench's own pixel table. When READOUT_CRC_EN is defined,
// the bench also expects the appended XOR beat.
// ---------------------------------------------------------------------------
module tb_pixel_readout;

    localparam int W = 3;
    localparam int H = 2;
    localparam int N = W * H;
`ifdef READOUT_CRC_EN
    localparam int BEATS = N + 1;
`else
    localparam int BEATS = N;
`endif

    logic           clk;
    logic           reset;
    logic [8*N-1:0] pixelDataIn;
    logic           frameValid;
    logic [7:0]     dataOut;
    logic           dataValid;
    logic           dataReady;
    logic           firstOut;
    logic           lastOut;
    logic           busy;
    logic           overrun;

    pixel_readout #(.W(W), .H(H), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .pixelDataIn (pixelDataIn),
        .frameValid  (frameValid),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .dataReady   (dataReady),
        .firstOut    (firstOut),
        .lastOut     (lastOut),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total  = 0;
    int         passed = 0;
    logic [7:0] pix [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge. Both sampling and driving
    // happen at this point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix();
        for (int k = 0; k < N; k++) pixelDataIn[8*k +: 8] = pix[k];
    endtask

    task automatic load_seq(input logic [7:0] base);
        for (int k = 0; k < N; k++) pix[k] = base + 8'(k);
        drive_pix();
    endtask

    task automatic send_frame();
        frameValid = 1'b1;
        tick();
        frameValid = 1'b0;
    endtask

    // Drain one frame and check every presented beat. With stall=1, dataReady
    // follows the pattern 1,0,0,1,0,0,... so each byte must hold while stalled.
    task automatic expect_stream(input string tag, input bit stall);
        int         k;
        int         c;
        logic [7:0] x;
        logic [7:0] exp_b;
        k = 0;
        c = 0;
        x = 8'h00;
        while (k < BEATS && c < 64) begin
            exp_b = (k < N) ? pix[k] : x;
            check($sformatf("%s_valid%0d", tag, k), dataValid, 1);
            check($sformatf("%s_data%0d",  tag, k), dataOut,   exp_b);
            check($sformatf("%s_first%0d", tag, k), firstOut,  (k == 0));
            check($sformatf("%s_last%0d",  tag, k), lastOut,   (k == BEATS - 1));
            dataReady = stall ? ((c % 3) == 0) : 1'b1;
            tick();
            if (dataReady) begin
                if (k < N) x = x ^ pix[k];
                k++;
            end
            c++;
        end
        dataReady = 1'b0;
        check({tag, "_beats"},      k,         BEATS);
        check({tag, "_valid_done"}, dataValid, 0);
        check({tag, "_busy_done"},  busy,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        frameValid  = 1'b0;
        dataReady   = 1'b0;
        pixelDataIn = '0;
        repeat (3) tick();

        // Reset values
        check("rst_dataOut",   dataOut,   0);
        check("rst_dataValid", dataValid, 0);
        check("rst_firstOut",  firstOut,  0);
        check("rst_lastOut",   lastOut,   0);
        check("rst_busy",      busy,      0);
        check("rst_overrun",   overrun,   0);
        reset = 1'b0;
        tick();
        check("idle_valid", dataValid, 0);

        // Reset mid-stream: two beats accepted, then an asynchronous reset
        load_seq(8'h50);
        dataReady = 1'b1;
        send_frame();
        check("mid_px0", dataOut, 8'h50);
        tick();
        tick();
        check("mid_px2", dataOut, 8'h52);
        dataReady = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("mid_rst_data",  dataOut,   0);
        check("mid_rst_valid", dataValid, 0);
        check("mid_rst_first", firstOut,  0);
        check("mid_rst_last",  lastOut,   0);
        check("mid_rst_busy",  busy,      0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_idle", dataValid, 0);

        // Basic full-throughput stream, starting again at pixel 0
        load_seq(8'h10);
        send_frame();
        expect_stream("basic", 1'b0);

        // Backpressure
        send_frame();
        expect_stream("bp", 1'b1);
        check("bp_overrun", overrun, 0);

        // Overrun: second frame during STREAM must be dropped
        send_frame();
        tick();
        for (int k = 0; k < N; k++) pixelDataIn[8*k +: 8] = 8'hA0 + 8'(k);
        frameValid = 1'b1;
        tick();
        frameValid = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy,    1);
        expect_stream("ovr", 1'b0);
        load_seq(8'h30);
        send_frame();
        check("third_overrun", overrun, 1);
        expect_stream("third", 1'b0);
        check("third_overrun_end", overrun, 1);

        // Back-to-back: a frame on the final handshake is dropped, and the
        // next cycle's frame is accepted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("b2b_overrun0", overrun, 0);
        load_seq(8'h60);
        dataReady = 1'b1;
        send_frame();
        repeat (BEATS - 1) tick();
        check("b2b_last", lastOut, 1);
        load_seq(8'h70);
        frameValid = 1'b1;
        tick();
        check("b2b_dropped_ovr", overrun,   1);
        check("b2b_idle",        dataValid, 0);
        tick();
        frameValid = 1'b0;
        dataReady  = 1'b0;
        expect_stream("b2b", 1'b0);

`ifdef READOUT_CRC_EN
        // Check byte: 01^02^04^08^10^20 = 3F
        for (int k = 0; k < N; k++) pix[k] = 8'h01 << k;
        drive_pix();
        send_frame();
        expect_stream("crc", 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
